// File: rtl/eth_tx_axis_arbiter_if.sv
// eth_tx_axis_arbiter_if: AXI-Stream packet bus carrying data, the 80-bit header in tuser, and keep.
interface eth_tx_axis_arbiter_if #(
    parameter int P_DATA_WIDTH = 64,
    parameter int P_USER_WIDTH = 80,
    parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8
);
    logic [P_DATA_WIDTH-1:0] tdata;
    logic [P_USER_WIDTH-1:0] tuser;
    logic [P_KEEP_WIDTH-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;
    modport master (output tdata, tuser, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tuser, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/eth_tx_axis_arbiter.sv
// eth_tx_axis_arbiter: two-source packet-level round-robin AXIS merger for the 10G TX path.
// The grant is held from the first beat to tlast; the datapath is a pure combinational mux.
module eth_tx_axis_arbiter (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    eth_tx_axis_arbiter_if.slave         s0_axis,
    eth_tx_axis_arbiter_if.slave         s1_axis,
    eth_tx_axis_arbiter_if.master        m_axis,
    output logic [1:0]                   o_grant,
    output logic [15:0]                  o_pkt_cnt0,
    output logic [15:0]                  o_pkt_cnt1
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t      state_q, state_d;
    logic        last_src_q, last_src_d;
    logic        mid_q, mid_d;
    logic [15:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic        g0, g1, xfer, eop0, eop1;
    always_comb begin
        g0 = state_q == GNT0;
        g1 = state_q == GNT1;
        m_axis.tdata   = g0 ? s0_axis.tdata  : g1 ? s1_axis.tdata  : '0;
        m_axis.tuser   = g0 ? s0_axis.tuser  : g1 ? s1_axis.tuser  : '0;
        m_axis.tkeep   = g0 ? s0_axis.tkeep  : g1 ? s1_axis.tkeep  : '0;
        m_axis.tlast   = g0 ? s0_axis.tlast  : g1 ? s1_axis.tlast  : 1'b0;
        m_axis.tvalid  = g0 ? s0_axis.tvalid : g1 ? s1_axis.tvalid : 1'b0;
        s0_axis.tready = g0 & m_axis.tready;
        s1_axis.tready = g1 & m_axis.tready;
        xfer = ((g0 & s0_axis.tvalid) | (g1 & s1_axis.tvalid)) & m_axis.tready;
        eop0 = g0 & xfer & s0_axis.tlast;
        eop1 = g1 & xfer & s1_axis.tlast;
        last_src_d = eop0 ? 1'b0 : eop1 ? 1'b1 : last_src_q;
        mid_d  = (eop0 | eop1) ? 1'b0 : xfer ? 1'b1 : mid_q;
        cnt0_d = (eop0 && cnt0_q != 16'hFFFF) ? cnt0_q + 16'd1 : cnt0_q;
        cnt1_d = (eop1 && cnt1_q != 16'hFFFF) ? cnt1_q + 16'd1 : cnt1_q;
        // Between packets an idle owner gives the bus back so the other source cannot starve.
        state_d = g0 ? (eop0 ? (s1_axis.tvalid ? GNT1 : s0_axis.tvalid ? GNT0 : IDLE)
                             : (!mid_q && !s0_axis.tvalid) ? IDLE : GNT0)
                : g1 ? (eop1 ? (s0_axis.tvalid ? GNT0 : s1_axis.tvalid ? GNT1 : IDLE)
                             : (!mid_q && !s1_axis.tvalid) ? IDLE : GNT1)
                : (s0_axis.tvalid && s1_axis.tvalid) ? (last_src_q ? GNT0 : GNT1)
                : s0_axis.tvalid ? GNT0 : s1_axis.tvalid ? GNT1 : IDLE;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            last_src_q <= 1'b1;
            mid_q      <= 1'b0;
            cnt0_q     <= '0;
            cnt1_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_src_q <= last_src_d;
            mid_q      <= mid_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
        end
    end
    assign o_grant    = {g1, g0};
    assign o_pkt_cnt0 = cnt0_q;
    assign o_pkt_cnt1 = cnt1_q;
endmodule

// File: doc/eth_tx_axis_arbiter.md
# eth_tx_axis_arbiter

Two-input, packet-level round-robin arbiter for the 10G Ethernet TX path. It merges two AXI-Stream packet sources, each carrying 64-bit data, 80-bit user header and 8-bit keep, onto one AXIS master toward the TX framing/MAC stage. A grant is held for a whole packet, from first beat to tlast. Per-source packet counters are provided for debug.

## Interface
- P_DATA_WIDTH, 64, tdata width.
- P_USER_WIDTH, 80, tuser width ({len[15:0], mac[47:0], type[15:0]}); carried through unmodified.
- P_KEEP_WIDTH, 8, tkeep width (P_DATA_WIDTH/8).
- i_clk  in  1  single clock for all logic.
- i_rst_n  in  1  asynchronous reset, active-low.
- s0_axis_tdata / tuser / tkeep  in  P_DATA_WIDTH / P_USER_WIDTH / P_KEEP_WIDTH  source 0 payload.
- s0_axis_tlast, s0_axis_tvalid  in  1  source 0 framing and valid.
- s0_axis_tready  out  1  ready to source 0.
- s1_axis_*  same widths and directions as s0  source 1.
- m_axis_tdata / tuser / tkeep  out  P_DATA_WIDTH / P_USER_WIDTH / P_KEEP_WIDTH  merged output.
- m_axis_tlast, m_axis_tvalid  out  1  merged framing and valid.
- m_axis_tready  in  1  downstream ready.
- o_grant  out  2  one-hot current grant ({s1,s0}); 2'b00 when idle.
- o_pkt_cnt0, o_pkt_cnt1  out  16  packets completed per source, saturating at 16'hFFFF.

## Operation
- States: IDLE, GNT0, GNT1. Registered r_last_src records the last served source.
- Beat transfer: x_tvalid & x_tready.
- **IDLE**
  - All sX_axis_tready = 0. All m_axis_* = 0. o_grant = 0.
  - Only s0_tvalid is high -> GNT0. Only s1_tvalid is high -> GNT1.
  - Both are high -> grant the source != r_last_src.
- **GNTx**
  - m_axis_* = sx_axis_* (combinational mux). sx_axis_tready = m_axis_tready. The other source's tready = 0. o_grant = one-hot x.
- **Packet end** (a transfer with tlast in GNTx)
  - r_last_src <= x; o_pkt_cnt[x] increments unless it is at 16'hFFFF.
  - Next state is chosen from the same-cycle tvalid of both sources, using the updated priority:
    - other source valid -> GNT(other);
    - else own source valid -> GNTx;
    - else IDLE.
- Grant is never revoked mid-packet. If sx_tvalid deasserts inside a packet, the block stays in GNTx and m_axis_tvalid follows the source low.
- A single-beat packet (tlast on the first beat) is a complete packet.
- tkeep and tuser are not inspected or modified.

## Timing
- Reset values:
  - state IDLE, r_last_src = 1 (so source 0 wins the first tie);
  - o_pkt_cnt0/1 = 0, o_grant = 0;
  - all m_axis_* outputs = 0, both sX_axis_tready = 0.
- Async reset mid-packet: outputs return to reset values immediately. The partial packet is abandoned with no tlast generated. Counters clear.
- Arbitration latency from IDLE: the first beat is offered on m_axis in the cycle after tvalid is first seen in IDLE.
- Back-to-back packets: zero bubble. The first beat of the next packet is offered in the cycle after the tlast transfer.
- Datapath latency inside a grant is 0 cycles: tdata, tvalid and tready are combinational through the mux. No buffering.
- If m_axis_tready is held low, no state change, no counter change, and the payload stays stable. AXIS stability is inherited from the source.
- Simultaneous tlast transfer and new valid on both sources: the other source wins, giving strict alternation under full load.

## Test plan
- **Single source.** Source 0 sends a 10-beat packet, m_axis_tready = 1.
  - o_grant = 01 one cycle after s0_tvalid rises.
  - 10 beats appear unchanged; tuser = {16'd10, 48'h010203040506, 16'h0800}.
  - o_pkt_cnt0 = 1, then return to IDLE.
- **Both sources, continuous traffic.** Both present 10-beat packets continuously.
  - Grants go 0,1,0,1 with no idle cycle between packets.
  - After 4 packets, o_pkt_cnt0 = o_pkt_cnt1 = 2.
- **Backpressure.** m_axis_tready toggles 1010… during a packet, and s1 is valid throughout.
  - s0 beats are transferred only on ready cycles.
  - s1_axis_tready stays 0 until s0's tlast transfer.
- **Source stall.** s0 drops tvalid for 3 cycles mid-packet while s1 is valid.
  - Grant stays on s0, m_axis_tvalid = 0 for those 3 cycles, and no s1 beats leak through.
- **Reset mid-packet.** i_rst_n is pulsed low at beat 5 of an s1 packet.
  - All outputs go to 0 immediately and the counters clear.
  - After release, the next tie is won by s0.
- **Counter saturation and single-beat packets.** Force o_pkt_cnt0 to 16'hFFFE, then send single-beat packets.
  - The counter reads FFFF and stays at FFFF.
